// File: rtl/insn_loader.sv
// insn_loader: byte-stream program loader for the rv32i instruction memory.
//
// Accepts a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, XOR checksum)
// over a valid/ready handshake. It assembles little-endian 32-bit words and
// writes them to sequential word addresses starting at 0. The core is held in
// reset until the checksum verifies.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   start               single-cycle pulse, honoured in IDLE, DONE or ERROR
//   in_valid, in_data   byte stream input
//   in_ready            a byte is accepted this cycle when in_valid is high
//   mem_we, mem_addr,   one-cycle instruction-memory write port
//   mem_wdata
//   core_hold           high keeps the core in reset
//   done, error         load status levels
//   words_loaded        words written in the current or last load
module insn_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam int unsigned Capacity = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [23:0]           asm_q, asm_d;     // lower three bytes of the word in flight
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [15:0]           words_q, words_d;

    logic        accept;
    logic [15:0] len_new;
    logic [15:0] word_idx_ext;

    always_comb begin
        in_ready = (state_q == StLen0) || (state_q == StLen1) ||
                   (state_q == StData) || (state_q == StCheck);
    end

    assign accept       = in_valid && in_ready;
    assign len_new      = {in_data, len_q[7:0]};
    assign word_idx_ext = 16'(word_idx_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLen0;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    words_d    = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    if (len_new == 16'd0) begin
                        state_d = StCheck;
                    end else if (32'(len_new) > Capacity) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        2'd3: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = word_idx_q;
                            mem_wdata_d = {in_data, asm_q};
                            words_d     = words_q + 16'd1;
                            word_idx_d  = word_idx_q + 1'b1;
                            if (word_idx_ext == len_q - 16'd1) begin
                                state_d = StCheck;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StError);
    assign core_hold    = (state_q != StDone);

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: table-driven frames with a write
// scoreboard, plus a hand-written asynchronous-reset-mid-load sequence.
module tb_insn_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [15:0]   words_loaded;

    insn_loader #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_hold   (core_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];

    logic [31:0] shadow  [1024];
    bit          written [1024];
    logic        we_prev = 1'b0;

    typedef struct {
        string           name;
        int              nbytes;
        logic [15:0][7:0] b;
        int              gap;
        logic            exp_done;
        logic            exp_err;
        int              exp_words;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wr_t e;
                checks++;
                if (we_prev) begin
                    errors++;
                    $display("FAIL we_width: mem_we high two cycles running at addr %0d", mem_addr);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
                shadow[mem_addr]  = mem_wdata;
                written[mem_addr] = 1'b1;
            end
            we_prev = mem_we;
        end else begin
            we_prev = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hxx;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_hold", 32'(core_hold), 32'd1);
        check("start_clear", {done, error, words_loaded}, 32'd0);
    endtask

    // Send the first nsend bytes of a frame, pushing expected writes as data is driven.
    task automatic send_frame(input vec_t v, input int nsend);
        int          n;
        int          k;
        logic [31:0] acc;
        wr_t         w;
        n   = int'({v.b[1], v.b[0]});
        acc = '0;
        for (int i = 0; i < nsend; i++) begin
            if (i >= 2 && i < 2 + 4 * n) begin
                k = i - 2;
                acc[(k % 4) * 8 +: 8] = v.b[i];
                if (k % 4 == 3) begin
                    w.addr = AW'(k / 4);
                    w.data = acc;
                    exp_q.push_back(w);
                end
            end
            send_byte(v.b[i], v.gap);
        end
    endtask

    task automatic run_vec(input vec_t v);
        pulse_start();
        send_frame(v, v.nbytes);
        check({v.name, "_done"},  32'(done),  32'(v.exp_done));
        check({v.name, "_error"}, 32'(error), 32'(v.exp_err));
        check({v.name, "_hold"},  32'(core_hold), 32'(!v.exp_done));
        check({v.name, "_words"}, 32'(words_loaded), 32'(v.exp_words));
        check({v.name, "_ready"}, 32'(in_ready), 32'd0);
        check({v.name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    vec_t vecs[6];
    vec_t nominal;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nominal.name   = "nominal";
        nominal.nbytes = 15;
        nominal.b      = '0;
        nominal.b[0]  = 8'h03; nominal.b[1]  = 8'h00;
        nominal.b[2]  = 8'h93; nominal.b[3]  = 8'h80; nominal.b[4]  = 8'hE0; nominal.b[5]  = 8'hFF;
        nominal.b[6]  = 8'h13; nominal.b[7]  = 8'h01; nominal.b[8]  = 8'hD1; nominal.b[9]  = 8'hFF;
        nominal.b[10] = 8'hB3; nominal.b[11] = 8'hA1; nominal.b[12] = 8'h20; nominal.b[13] = 8'h00;
        nominal.b[14] = 8'h02;
        nominal.gap       = 0;
        nominal.exp_done  = 1'b1;
        nominal.exp_err   = 1'b0;
        nominal.exp_words = 3;

        vecs[0] = nominal;
        vecs[1] = nominal;
        vecs[1].name = "badsum"; vecs[1].b[14] = 8'h03;
        vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1;
        vecs[2] = nominal;
        vecs[2].name = "reload";
        vecs[3] = nominal;
        vecs[3].name = "overflow"; vecs[3].nbytes = 2;
        vecs[3].b[0] = 8'h01; vecs[3].b[1] = 8'h04;
        vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b1; vecs[3].exp_words = 0;
        vecs[4] = nominal;
        vecs[4].name = "zero"; vecs[4].nbytes = 3;
        vecs[4].b[0] = 8'h00; vecs[4].b[1] = 8'h00; vecs[4].b[2] = 8'h00;
        vecs[4].exp_words = 0;
        vecs[5] = nominal;
        vecs[5].name = "throttled"; vecs[5].gap = 3;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        #12;
        check("reset_ready", 32'(in_ready), 32'd0);
        check("reset_hold", 32'(core_hold), 32'd1);
        check("reset_outs", {mem_we, done, error, words_loaded}, 32'd0);
        check("reset_mem", {mem_addr, mem_wdata[21:0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Overflow frame must not have written anything past the three nominal words.
        check("overflow_nowrite", 32'(written[3]), 32'd0);

        // Asynchronous reset mid-load: two length bytes plus six data bytes.
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        pulse_start();
        send_frame(nominal, 8);
        #2;
        reset = 1'b1;
        #1;
        check("areset_ready", 32'(in_ready), 32'd0);
        check("areset_hold", 32'(core_hold), 32'd1);
        check("areset_outs", {mem_we, done, error, words_loaded}, 32'd0);
        check("areset_addr", 32'(mem_addr), 32'd0);
        check("areset_wdata", mem_wdata, 32'd0);
        check("areset_mem0", shadow[0], 32'hFFE08093);
        check("areset_mem1_untouched", 32'(written[1]), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vecs[0].name = "restart";
        run_vec(vecs[0]);
        check("restart_mem2", shadow[2], 32'h0020A1B3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
